// File: rtl/carpark_multilane_ctrl_if.sv
// ============================================================================
// Module   : carpark_multilane_ctrl_if
// Brief    : Sensor, recalibration and status bundle for the car park controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface carpark_multilane_ctrl_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 7
);
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
    logic [LANES-1:0] enter;
    logic [LANES-1:0] exit;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [LANES-1:0] err;
    logic             ovf;

    modport master (
        output a, b, load_en, load_val,
        input  enter, exit, count, full, empty, err, ovf
    );

    modport slave (
        input  a, b, load_en, load_val,
        output enter, exit, count, full, empty, err, ovf
    );
endinterface

`default_nettype wire

// File: rtl/carpark_multilane_ctrl.sv
// ============================================================================
// Module   : carpark_multilane_ctrl
// Brief    : Per-lane beam-sensor decoding into enter/exit pulses feeding a
//            shared saturating occupancy counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module carpark_multilane_ctrl #(
    parameter int LANES    = 2,
    parameter int CAPACITY = 100,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic clk,
    input  logic reset,
    carpark_multilane_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int SUM_W = CNT_W + $clog2(LANES) + 2;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    logic [LANES-1:0] w_enter;
    logic [LANES-1:0] w_exit;
    logic [LANES-1:0] w_err;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            // Bit 1 carries sensor a, bit 0 sensor b, so patterns read as {a,b}.
            logic [1:0]      w_raw;
            logic [1:0]      r_s1;
            logic [1:0]      r_s2;
            logic [1:0]      r_filt;
            logic [DB_W-1:0] r_db [2];
            state_t          r_state;
            logic [TO_W-1:0] r_tcnt;
            logic            r_enter;
            logic            r_exit;
            logic            r_err;

            assign w_raw = {bus.a[i], bus.b[i]};

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s1     <= '0;
                    r_s2     <= '0;
                    r_filt   <= '0;
                    r_db[0]  <= '0;
                    r_db[1]  <= '0;
                end else begin
                    r_s1 <= w_raw;
                    r_s2 <= r_s1;
                    for (int j = 0; j < 2; j++) begin
                        if (r_s2[j] != r_filt[j]) begin
                            if (r_db[j] == DB_W'(DEBOUNCE - 1)) begin
                                r_filt[j] <= r_s2[j];
                                r_db[j]   <= '0;
                            end else begin
                                r_db[j] <= r_db[j] + DB_W'(1);
                            end
                        end else begin
                            r_db[j] <= '0;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= IDLE;
                    r_tcnt  <= '0;
                    r_enter <= 1'b0;
                    r_exit  <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_enter <= 1'b0;
                    r_exit  <= 1'b0;
                    r_err   <= 1'b0;
                    if (r_state == IDLE || r_state == WAIT_CLR)
                        r_tcnt <= '0;
                    else
                        r_tcnt <= r_tcnt + TO_W'(1);

                    // A stalled sequence overrides whatever the sensors say this cycle.
                    if (r_state != IDLE && r_state != WAIT_CLR &&
                        r_tcnt == TO_W'(TIMEOUT - 1)) begin
                        r_state <= WAIT_CLR;
                        r_err   <= 1'b1;
                    end else begin
                        case (r_state)
                            IDLE: case (r_filt)
                                2'b10:   r_state <= EN1;
                                2'b01:   r_state <= EX1;
                                2'b11:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EN1: case (r_filt)
                                2'b11:   r_state <= EN2;
                                2'b00:   r_state <= IDLE;
                                2'b01:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EN2: case (r_filt)
                                2'b01:   r_state <= EN3;
                                2'b10:   r_state <= EN1;
                                2'b00:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EN3: case (r_filt)
                                2'b00:   begin r_state <= IDLE; r_enter <= 1'b1; end
                                2'b11:   r_state <= EN2;
                                2'b10:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EX1: case (r_filt)
                                2'b11:   r_state <= EX2;
                                2'b00:   r_state <= IDLE;
                                2'b10:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EX2: case (r_filt)
                                2'b10:   r_state <= EX3;
                                2'b01:   r_state <= EX1;
                                2'b00:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            EX3: case (r_filt)
                                2'b00:   begin r_state <= IDLE; r_exit <= 1'b1; end
                                2'b11:   r_state <= EX2;
                                2'b01:   begin r_state <= WAIT_CLR; r_err <= 1'b1; end
                                default: ;
                            endcase
                            WAIT_CLR: if (r_filt == 2'b00) r_state <= IDLE;
                            default:  r_state <= IDLE;
                        endcase
                    end
                end
            end

            assign w_enter[i] = r_enter;
            assign w_exit[i]  = r_exit;
            assign w_err[i]   = r_err;
        end
    endgenerate

    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic signed [SUM_W-1:0] w_next;

    // Entries and exits from different lanes net out before any clamping.
    always_comb begin
        w_next = $signed({{(SUM_W - CNT_W){1'b0}}, r_count});
        for (int i = 0; i < LANES; i++) begin
            w_next = w_next + $signed(SUM_W'(w_enter[i])) - $signed(SUM_W'(w_exit[i]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.load_en) begin
            if (bus.load_val > CNT_W'(CAPACITY)) begin
                r_count <= CNT_W'(CAPACITY);
                r_ovf   <= 1'b1;
            end else begin
                r_count <= bus.load_val;
                r_ovf   <= 1'b0;
            end
        end else if (w_next[SUM_W-1]) begin
            r_count <= '0;
            r_ovf   <= 1'b1;
        end else if (w_next > CAP_S) begin
            r_count <= CNT_W'(CAPACITY);
            r_ovf   <= 1'b1;
        end else begin
            r_count <= w_next[CNT_W-1:0];
            r_ovf   <= 1'b0;
        end
    end

    assign bus.enter = w_enter;
    assign bus.exit  = w_exit;
    assign bus.err   = w_err;
    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
    assign bus.full  = (r_count == CNT_W'(CAPACITY));
    assign bus.empty = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_carpark_multilane_ctrl.sv
// ============================================================================
// Module   : tb_carpark_multilane_ctrl
// Brief    : Directed and randomized bench against a sequence-level car park model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_carpark_multilane_ctrl;

    localparam int LANES    = 2;
    localparam int CAPACITY = 100;
    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 100;
    localparam int CNT_W    = $clog2(CAPACITY + 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    carpark_multilane_ctrl_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    carpark_multilane_ctrl #(
        .LANES(LANES), .CAPACITY(CAPACITY), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_en  [LANES];
    int n_ex  [LANES];
    int n_err [LANES];
    int n_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sensor pattern {a,b} at step idx of an entry (dir 0) or exit (dir 1) pass.
    function automatic logic [1:0] seq_pat(input int dir, input int idx);
        logic [1:0] r;
        case (idx)
            0:       r = (dir != 0) ? 2'b01 : 2'b10;
            1:       r = 2'b11;
            2:       r = (dir != 0) ? 2'b10 : 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 entering, 2 exiting, 3 waiting for clear
    longint           cyc;
    int               m_count;
    logic             m_ovf;
    logic [LANES-1:0] m_enter, m_exit, m_err;
    logic [1:0]       m_filt [LANES];
    logic [1:0]       m_hist [LANES][DEBOUNCE+1];
    int               m_mode [LANES];
    int               m_pos  [LANES];
    longint           m_start[LANES];
    int               t_nxt, t_dir;
    logic [1:0]       t_p, t_nf;
    logic             t_flip;

    always @(posedge clk) begin
        if (!reset) begin
            cyc = 0; m_count = 0; m_ovf = 1'b0;
            m_enter = '0; m_exit = '0; m_err = '0;
            for (int l = 0; l < LANES; l++) begin
                m_filt[l] = 2'b00; m_mode[l] = 0; m_pos[l] = 0; m_start[l] = 0;
                for (int k = 0; k <= DEBOUNCE; k++) m_hist[l][k] = 2'b00;
            end
        end else begin
            cyc++;
            if (bus.load_en) begin
                m_ovf   = (int'(bus.load_val) > CAPACITY);
                m_count = m_ovf ? CAPACITY : int'(bus.load_val);
            end else begin
                t_nxt = m_count + $countones(m_enter) - $countones(m_exit);
                m_ovf = (t_nxt > CAPACITY) || (t_nxt < 0);
                m_count = (t_nxt > CAPACITY) ? CAPACITY : (t_nxt < 0) ? 0 : t_nxt;
            end
            m_enter = '0; m_exit = '0; m_err = '0;
            for (int l = 0; l < LANES; l++) begin
                t_p = m_filt[l];
                if ((m_mode[l] == 1 || m_mode[l] == 2) && (cyc - m_start[l] == TIMEOUT)) begin
                    m_mode[l] = 3; m_err[l] = 1'b1;
                end else begin
                    case (m_mode[l])
                        0: begin
                            if (t_p == 2'b10) begin m_mode[l] = 1; m_pos[l] = 0; m_start[l] = cyc; end
                            else if (t_p == 2'b01) begin m_mode[l] = 2; m_pos[l] = 0; m_start[l] = cyc; end
                            else if (t_p == 2'b11) begin m_mode[l] = 3; m_err[l] = 1'b1; end
                        end
                        1, 2: begin
                            t_dir = m_mode[l] - 1;
                            if (t_p == seq_pat(t_dir, m_pos[l])) begin
                            end else if (t_p == seq_pat(t_dir, m_pos[l] + 1)) begin
                                if (m_pos[l] == 2) begin
                                    m_mode[l] = 0;
                                    if (t_dir == 0) m_enter[l] = 1'b1; else m_exit[l] = 1'b1;
                                end else m_pos[l]++;
                            end else if (m_pos[l] > 0 && t_p == seq_pat(t_dir, m_pos[l] - 1)) begin
                                m_pos[l]--;
                            end else if (m_pos[l] == 0 && t_p == 2'b00) begin
                                m_mode[l] = 0;
                            end else begin
                                m_mode[l] = 3; m_err[l] = 1'b1;
                            end
                        end
                        default: if (t_p == 2'b00) m_mode[l] = 0;
                    endcase
                end
                // A filtered bit flips once the last DEBOUNCE synchronised samples all disagree with it.
                t_nf = m_filt[l];
                for (int j = 0; j < 2; j++) begin
                    t_flip = 1'b1;
                    for (int k = 1; k <= DEBOUNCE; k++)
                        if (m_hist[l][k][j] == m_filt[l][j]) t_flip = 1'b0;
                    if (t_flip) t_nf[j] = ~m_filt[l][j];
                end
                m_filt[l] = t_nf;
                for (int k = DEBOUNCE; k >= 1; k--) m_hist[l][k] = m_hist[l][k-1];
                m_hist[l][0] = {bus.a[l], bus.b[l]};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_enter", 32'(bus.enter), 0);
            chk("rst_exit",  32'(bus.exit),  0);
            chk("rst_err",   32'(bus.err),   0);
            chk("rst_ovf",   32'(bus.ovf),   0);
            chk("rst_count", 32'(bus.count), 0);
            chk("rst_full",  32'(bus.full),  0);
            chk("rst_empty", 32'(bus.empty), 1);
        end else begin
            chk("enter", 32'(bus.enter), 32'(m_enter));
            chk("exit",  32'(bus.exit),  32'(m_exit));
            chk("err",   32'(bus.err),   32'(m_err));
            chk("ovf",   32'(bus.ovf),   32'(m_ovf));
            chk("count", 32'(bus.count), 32'(m_count));
            chk("full",  32'(bus.full),  32'(m_count == CAPACITY));
            chk("empty", 32'(bus.empty), 32'(m_count == 0));
        end
        for (int l = 0; l < LANES; l++) begin
            if (bus.enter[l] === 1'b1) n_en[l]++;
            if (bus.exit[l]  === 1'b1) n_ex[l]++;
            if (bus.err[l]   === 1'b1) n_err[l]++;
        end
        if (bus.ovf === 1'b1) n_ovf++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [LANES-1:0] av, input logic [LANES-1:0] bv, input int hold);
        bus.a = av;
        bus.b = bv;
        tick(hold);
    endtask

    task automatic load(input int v);
        bus.load_en  = 1'b1;
        bus.load_val = CNT_W'(v);
        tick(1);
        bus.load_en  = 1'b0;
        tick(2);
    endtask

    task automatic clear_counts();
        for (int l = 0; l < LANES; l++) begin n_en[l] = 0; n_ex[l] = 0; n_err[l] = 0; end
        n_ovf = 0;
    endtask

    logic [LANES-1:0] av, bv;
    logic [1:0]       pat [LANES];
    int               st  [LANES];
    int               dir [LANES];
    int               got;

    initial begin
        bus.a = '0; bus.b = '0; bus.load_en = 1'b0; bus.load_val = '0;
        clear_counts();
        tick(3);
        chk("init_count", 32'(bus.count), 0);
        chk("init_empty", 32'(bus.empty), 1);
        chk("init_full",  32'(bus.full),  0);
        reset = 1'b1;
        tick(2);

        // Lane0 full entry
        clear_counts();
        drive(2'b01, 2'b00, 10); drive(2'b01, 2'b01, 10); drive(2'b00, 2'b01, 10); drive(2'b00, 2'b00, 12);
        chk("t1_enter_pulses", n_en[0], 1);
        chk("t1_count", 32'(bus.count), 1);
        chk("t1_empty", 32'(bus.empty), 0);

        // Lane1 exit at 3, then at 0 (clamped)
        load(3);
        clear_counts();
        drive(2'b00, 2'b10, 10); drive(2'b10, 2'b10, 10); drive(2'b10, 2'b00, 10); drive(2'b00, 2'b00, 12);
        chk("t2_exit_pulses", n_ex[1], 1);
        chk("t2_count", 32'(bus.count), 2);
        load(0);
        clear_counts();
        drive(2'b00, 2'b10, 10); drive(2'b10, 2'b10, 10); drive(2'b10, 2'b00, 10); drive(2'b00, 2'b00, 12);
        chk("t2_exit_at_zero", n_ex[1], 1);
        chk("t2_count_zero", 32'(bus.count), 0);
        chk("t2_ovf_pulses", n_ovf, 1);

        // Car backs out, then illegal 11 from idle
        clear_counts();
        drive(2'b01, 2'b00, 10); drive(2'b01, 2'b01, 10); drive(2'b01, 2'b00, 10); drive(2'b00, 2'b00, 12);
        chk("t3_backout_enter", n_en[0], 0);
        chk("t3_backout_err", n_err[0], 0);
        chk("t3_backout_count", 32'(bus.count), 0);
        drive(2'b01, 2'b01, 12);
        chk("t3_err_pulse", n_err[0], 1);
        drive(2'b01, 2'b00, 10); drive(2'b00, 2'b01, 10); drive(2'b01, 2'b01, 10); drive(2'b00, 2'b00, 12);
        chk("t3_err_single", n_err[0], 1);
        chk("t3_no_enter", n_en[0], 0);

        // Simultaneous entries at CAPACITY-1, then entry + exit at 5
        load(CAPACITY - 1);
        clear_counts();
        drive(2'b11, 2'b00, 10); drive(2'b11, 2'b11, 10); drive(2'b00, 2'b11, 10); drive(2'b00, 2'b00, 12);
        chk("t4_count_cap", 32'(bus.count), CAPACITY);
        chk("t4_full", 32'(bus.full), 1);
        chk("t4_ovf", n_ovf, 1);
        load(5);
        clear_counts();
        drive(2'b01, 2'b10, 10); drive(2'b11, 2'b11, 10); drive(2'b10, 2'b01, 10); drive(2'b00, 2'b00, 12);
        chk("t4_net_enter", n_en[0], 1);
        chk("t4_net_exit", n_ex[1], 1);
        chk("t4_net_count", 32'(bus.count), 5);
        chk("t4_net_ovf", n_ovf, 0);
        clear_counts();
        load(120);
        chk("load_big_count", 32'(bus.count), CAPACITY);
        chk("load_big_ovf", n_ovf, 1);

        // Glitch rejection at the debounce boundary, then timeout
        clear_counts();
        drive(2'b01, 2'b00, 2); drive(2'b00, 2'b00, 12);
        drive(2'b01, 2'b01, DEBOUNCE - 1); drive(2'b00, 2'b00, 12);
        chk("t5_spike_err", n_err[0], 0);
        drive(2'b01, 2'b01, DEBOUNCE); drive(2'b00, 2'b00, 12);
        chk("t5_accepted_err", n_err[0], 1);
        clear_counts();
        drive(2'b01, 2'b00, TIMEOUT + 20);
        chk("t5_timeout_err", n_err[0], 1);
        chk("t5_timeout_enter", n_en[0], 0);
        drive(2'b00, 2'b00, 12);
        drive(2'b01, 2'b00, 10); drive(2'b01, 2'b01, 10); drive(2'b00, 2'b01, 10); drive(2'b00, 2'b00, 12);
        chk("t5_idle_again", n_en[0], 1);

        // Load in the same cycle as an enter pulse
        load(10);
        clear_counts();
        drive(2'b01, 2'b00, 10); drive(2'b01, 2'b01, 10); drive(2'b00, 2'b01, 10);
        bus.a = '0; bus.b = '0;
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (bus.enter[0] === 1'b1) got = 1;
        end
        chk("t6_enter_seen", got, 1);
        bus.load_en = 1'b1; bus.load_val = CNT_W'(50);
        @(posedge clk); #2;
        bus.load_en = 1'b0;
        tick(3);
        chk("t6_load_wins", 32'(bus.count), 50);

        // Reset mid-EN2
        drive(2'b01, 2'b00, 10); drive(2'b01, 2'b01, 10);
        reset = 1'b0;
        bus.a = '0; bus.b = '0;
        tick(1);
        chk("t6_rst_count", 32'(bus.count), 0);
        chk("t6_rst_empty", 32'(bus.empty), 1);
        tick(4);
        reset = 1'b1;
        clear_counts();
        tick(20);
        chk("t6_post_rst_enter", n_en[0], 0);
        chk("t6_post_rst_err", n_err[0], 0);

        // Randomized walks, mostly legal sequences with occasional junk and loads
        for (int l = 0; l < LANES; l++) begin st[l] = 3; dir[l] = l % 2; end
        for (int it = 0; it < 400; it++) begin
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 4) == 0) begin
                    pat[l] = 2'($urandom_range(0, 3));
                end else begin
                    st[l]  = (st[l] + 1) % 4;
                    pat[l] = seq_pat(dir[l], st[l]);
                    if (st[l] == 3) dir[l] = int'($urandom_range(0, 1));
                end
                av[l] = pat[l][1];
                bv[l] = pat[l][0];
            end
            bus.a = av;
            bus.b = bv;
            if ($urandom_range(0, 15) == 0) begin
                bus.load_en  = 1'b1;
                bus.load_val = CNT_W'($urandom_range(0, 127));
                tick(1);
                bus.load_en  = 1'b0;
            end
            tick($urandom_range(1, 14));
        end
        drive('0, '0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
